memory_arbiter: RTL
===================

# memory_arbiter

Memory-side responder for the CPU request unit. It accepts the datapath's instruction-read, data-read and data-write requests, serialises them onto a single-ported RAM with variable latency, and returns single-cycle `ihit`/`dhit` pulses with the loaded word. It sits between the datapath/request unit and the RAM model. Data requests have priority over instruction fetches.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum number of RAM wait cycles before an access is aborted. Range 1..255.
- `WORD_W`, default 32: width of addresses and data words.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `imemREN` in 1: instruction read request, level.
- `imemaddr` in WORD_W: instruction address.
- `dmemREN` in 1: data read request, level.
- `dmemWEN` in 1: data write request, level.
- `dmemaddr` in WORD_W: data address.
- `dmemstore` in WORD_W: data write word.
- `ihit` out 1: instruction access complete, one-cycle pulse.
- `dhit` out 1: data access complete, one-cycle pulse.
- `imemload` out WORD_W: fetched instruction, registered.
- `dmemload` out WORD_W: loaded data word, registered.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out WORD_W: RAM address.
- `ramstore` out WORD_W: RAM write data.
- `ramload` in WORD_W: RAM read data, valid when `ramready` is 1.
- `ramready` in 1: RAM access done, one-cycle pulse.
- `memerr` out 1: sticky timeout flag.

## Operation

- FSM states: IDLE, DACC, IACC, DONE. Reset state is IDLE.
- **IDLE:**
  - If `dmemWEN` or `dmemREN` is set: latch `dmemaddr`, `dmemstore` and the op into internal registers, then go to DACC. If both are set, the access is a write.
  - Else if `imemREN` is set: latch `imemaddr`, then go to IACC.
  - Else stay in IDLE.
- **DACC / IACC:**
  - Drive `ramaddr`/`ramstore` from the latched registers. Assert `ramREN` or `ramWEN` per the latched op; IACC always asserts `ramREN`.
  - The wait counter starts at 0 on entry and increments each cycle.
  - On `ramready`:
    - For a data read, capture `ramload` into `dmemload`; for IACC, capture it into `imemload`.
    - Go to DONE.
  - If the counter reaches TIMEOUT without `ramready`: set `memerr`, drop the strobes and go to IDLE. No hit is produced and the load registers are unchanged.
- **DONE:**
  - `dhit` = 1 if the completed access was a data access and `dmemREN|dmemWEN` is still asserted.
  - `ihit` = 1 if the completed access was IACC and `imemREN` is still asserted.
  - A request withdrawn mid-access still completes in RAM, but its hit is suppressed.
  - Always go to IDLE next. Requests are ignored during DONE, which gives the request unit its one-cycle deassert window.
- The strobes are combinational from the state. `ramaddr` and `ramstore` come from the registers.
- `memerr` stays at 1 until `nRST`.
- `ramready` arriving in IDLE or DONE is ignored.
- Requests in IDLE on the same edge as a timeout abort are not sampled until the next IDLE cycle.

## Timing

- **Reset values:**
  - 0: `ihit`, `dhit`, `ramREN`, `ramWEN`, `memerr`.
  - All zeros: `ramaddr`, `ramstore`, `imemload`, `dmemload`.
  - The strobes fall asynchronously on `nRST` low, including mid-access. Any pending access is lost.
- **Latency:** request sampled in IDLE at cycle 0 → strobe in cycle 1 → `ramready` at earliest in cycle 1 → hit in cycle 2. Each RAM wait cycle adds 1.
- **Throughput:** at most one access per 3 cycles with zero-wait RAM.
- **Load registers:** `imemload`/`dmemload` are valid in the hit cycle and hold until the next capture.
- **Simultaneous requests:** with instruction and data requested together, data is served first and instruction next. The minimum is 3 cycles from the `dhit` to the `ihit` for zero-wait RAM.
- **Counter width:** 8 bits, no wrap. The abort fires on the cycle the count equals TIMEOUT.

## Test plan

1. **Reset mid-access:** reset with `imemREN`=1, `imemaddr`=0x40, then release. After release, `ramREN`=1 with `ramaddr`=0x40 in the cycle after the first IDLE; `ramready` with `ramload`=0xDEADBEEF → `ihit`=1 exactly one cycle later with `imemload`=0xDEADBEEF. Then assert `nRST` low mid-IACC → strobes drop immediately and all outputs return to 0.
2. **Contention:** `imemREN`=1 and `dmemREN`=1 (`dmemaddr`=0x100) together, 2-wait RAM → `dhit` first with `dmemload` = RAM word, then `ihit` ≥3 cycles later. Check no other order occurs.
3. **Write:** `dmemWEN`=1, `dmemaddr`=0x200, `dmemstore`=0x12345678 → `ramWEN`=1 with matching addr/data and `ramREN`=0. `dhit` comes one cycle after `ramready`; `dmemload` is unchanged.
4. **Withdrawn request:** drop `imemREN` mid-IACC → the RAM access completes and `ihit` stays 0 in DONE. The next request is served normally.
5. **Timeout:** TIMEOUT=4 and `ramready` never asserted → strobes drop after 4 access cycles, `memerr`=1 and no hit. A following access works, and `memerr` stays 1 until reset.
6. **Both data strobes:** `dmemREN`=`dmemWEN`=1 → write performed and one `dhit`.

Source files
------------

// File: rtl/memory_arbiter.sv
// Serialises instruction-read, data-read and data-write requests onto a
// single-ported, variable-latency RAM; data requests win over fetches.
module memory_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready,
    output logic              memerr
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic              wr_q;
    logic              data_q;
    logic [7:0]        cnt;
    logic              timeout_hit;

    // The abort edge is the one on which the incremented count reaches TIMEOUT,
    // so the strobes are held for exactly TIMEOUT access cycles.
    assign timeout_hit = (cnt + 8'd1) == TIMEOUT_CNT;
    assign ramaddr     = addr_q;
    assign ramstore    = store_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        case (state)
            IDLE: begin
                if (dmemWEN || dmemREN) begin
                    state_next = DACC;
                end else if (imemREN) begin
                    state_next = IACC;
                end
            end
            DACC, IACC: begin
                ramREN = (state == IACC) || !wr_q;
                ramWEN = (state == DACC) && wr_q;
                if (ramready) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                // Hits are gated by the live request so a withdrawn access stays silent.
                dhit       = data_q && (dmemREN || dmemWEN);
                ihit       = !data_q && imemREN;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            data_q   <= 1'b0;
            cnt      <= 8'd0;
            imemload <= '0;
            dmemload <= '0;
            memerr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (dmemWEN || dmemREN) begin
                        addr_q  <= dmemaddr;
                        store_q <= dmemstore;
                        wr_q    <= dmemWEN;
                        data_q  <= 1'b1;
                    end else if (imemREN) begin
                        addr_q <= imemaddr;
                        wr_q   <= 1'b0;
                        data_q <= 1'b0;
                    end
                end
                DACC, IACC: begin
                    cnt <= cnt + 8'd1;
                    if (ramready) begin
                        if (state == IACC) begin
                            imemload <= ramload;
                        end else if (!wr_q) begin
                            dmemload <= ramload;
                        end
                    end else if (timeout_hit) begin
                        memerr <= 1'b1;
                    end
                end
                default: cnt <= 8'd0;
            endcase
        end
    end

endmodule
